// File: rtl/regfile_sb_param_if.sv
// Register-file port bundle: decode/writeback side drives the master modport,
// the register file itself sits on the slave modport.
interface regfile_sb_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              EN;
  logic              write;
  logic [ADDR_W-1:0] selectW1;
  logic [DATA_W-1:0] wdata1;
  logic              write2;
  logic [ADDR_W-1:0] selectW2;
  logic [DATA_W-1:0] wdata2;
  logic              reserve;
  logic [ADDR_W-1:0] selectRes;
  logic              read;
  logic [ADDR_W-1:0] selectR1;
  logic [ADDR_W-1:0] selectR2;
  logic [DATA_W-1:0] outA;
  logic [DATA_W-1:0] outB;
  logic              busyA;
  logic              busyB;

  modport master (
    output EN, write, selectW1, wdata1, write2, selectW2, wdata2,
           reserve, selectRes, read, selectR1, selectR2,
    input  outA, outB, busyA, busyB
  );

  modport slave (
    input  EN, write, selectW1, wdata1, write2, selectW2, wdata2,
           reserve, selectRes, read, selectR1, selectR2,
    output outA, outB, busyA, busyB
  );
endinterface

// File: rtl/regfile_sb_param.sv
// Dual-write, dual-read register file with same-cycle write forwarding and a
// per-register busy scoreboard tracking pending writebacks.
module regfile_sb_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  regfile_sb_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;
  logic [DATA_W-1:0] outa_reg, outb_reg;
  logic [DATA_W-1:0] outa_next, outb_next;
  logic              busya_reg, busyb_reg;
  logic              wr1, wr2, res, rd;

  assign wr1 = bus.EN & bus.write;
  assign wr2 = bus.EN & bus.write2;
  assign res = bus.EN & bus.reserve;
  assign rd  = bus.EN & bus.read;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam bit HARD_ZERO = ZERO_REG && (gi == 0);
      logic hit1, hit2, hitr;

      assign hit1 = wr1 && (bus.selectW1 == ADDR_W'(gi));
      assign hit2 = wr2 && (bus.selectW2 == ADDR_W'(gi));
      assign hitr = res && (bus.selectRes == ADDR_W'(gi));

      // A reservation in the same cycle as a write belongs to the next producer.
      assign busy_next[gi] = !HARD_ZERO && (hitr || (!(hit1 || hit2) && busy_reg[gi]));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (!HARD_ZERO && (hit1 || hit2)) begin
          regs_reg[gi] <= hit2 ? bus.wdata2 : bus.wdata1;
        end
      end
    end
  endgenerate

  function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] sel);
    logic [DATA_W-1:0] v;
    v = regs_reg[sel];
    if (BYPASS) begin
      if (wr2 && bus.selectW2 == sel) begin
        v = bus.wdata2;
      end else if (wr1 && bus.selectW1 == sel) begin
        v = bus.wdata1;
      end
    end
    if (ZERO_REG && sel == '0) begin
      v = '0;
    end
    return v;
  endfunction

  assign outa_next = read_value(bus.selectR1);
  assign outb_next = read_value(bus.selectR2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // Busy outputs reflect the scoreboard after this edge's reserve/write updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outa_reg  <= '0;
      outb_reg  <= '0;
      busya_reg <= 1'b0;
      busyb_reg <= 1'b0;
    end else if (rd) begin
      outa_reg  <= outa_next;
      outb_reg  <= outb_next;
      busya_reg <= busy_next[bus.selectR1];
      busyb_reg <= busy_next[bus.selectR2];
    end
  end

  assign bus.outA  = outa_reg;
  assign bus.outB  = outb_reg;
  assign bus.busyA = busya_reg;
  assign bus.busyB = busyb_reg;
endmodule

// File: tb/tb_regfile_sb_param.sv
// Checks three register-file configurations against directed vectors and a
// behavioural model under random traffic, including asynchronous resets.
module tb_regfile_sb_param;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NI = 3;

  typedef struct {
    logic          en, wr;
    logic [AW-1:0] sw1;
    logic [DW-1:0] wd1;
    logic          wr2;
    logic [AW-1:0] sw2;
    logic [DW-1:0] wd2;
    logic          res;
    logic [AW-1:0] sres;
    logic          rd;
    logic [AW-1:0] sr1, sr2;
  } stim_t;

  typedef struct {
    stim_t         s;
    logic [DW-1:0] ea, eb;
    logic          eba, ebb;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  stim_t cur;
  int    total = 0;
  int    bad   = 0;
  int    txn   = 0;

  // Instance 0: zero reg + bypass, 1: zero reg without bypass, 2: bypass without zero reg.
  bit zr [NI] = '{1'b1, 1'b1, 1'b0};
  bit bp [NI] = '{1'b1, 1'b0, 1'b1};

  logic [DW-1:0] dut_a [NI];
  logic [DW-1:0] dut_b [NI];
  logic          dut_ba [NI];
  logic          dut_bb [NI];

  regfile_sb_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus [NI] ();

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      assign bus[gi].EN        = cur.en;
      assign bus[gi].write     = cur.wr;
      assign bus[gi].selectW1  = cur.sw1;
      assign bus[gi].wdata1    = cur.wd1;
      assign bus[gi].write2    = cur.wr2;
      assign bus[gi].selectW2  = cur.sw2;
      assign bus[gi].wdata2    = cur.wd2;
      assign bus[gi].reserve   = cur.res;
      assign bus[gi].selectRes = cur.sres;
      assign bus[gi].read      = cur.rd;
      assign bus[gi].selectR1  = cur.sr1;
      assign bus[gi].selectR2  = cur.sr2;
      assign dut_a[gi]  = bus[gi].outA;
      assign dut_b[gi]  = bus[gi].outB;
      assign dut_ba[gi] = bus[gi].busyA;
      assign dut_bb[gi] = bus[gi].busyB;

      regfile_sb_param #(
        .DATA_W(DW), .ADDR_W(AW),
        .ZERO_REG(gi != 2), .BYPASS(gi != 1)
      ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus[gi])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  // Behavioural reference: architectural register contents and pending-write flags.
  logic [DW-1:0] m_regs [NI][2**AW];
  logic          m_busy [NI][2**AW];
  logic [DW-1:0] m_a [NI];
  logic [DW-1:0] m_b [NI];
  logic          m_ba [NI];
  logic          m_bb [NI];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int r = 0; r < 2**AW; r++) begin
        m_regs[k][r] = '0;
        m_busy[k][r] = 1'b0;
      end
      m_a[k] = '0; m_b[k] = '0; m_ba[k] = 1'b0; m_bb[k] = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] m_read(int k, logic [AW-1:0] sel);
    if (zr[k] && sel == 0) return '0;
    if (bp[k] && cur.wr2 && cur.sw2 == sel) return cur.wd2;
    if (bp[k] && cur.wr && cur.sw1 == sel) return cur.wd1;
    return m_regs[k][sel];
  endfunction

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      logic [DW-1:0] na, nb;
      if (cur.en) begin
        na = m_read(k, cur.sr1);
        nb = m_read(k, cur.sr2);
        if (cur.wr)  begin m_regs[k][cur.sw1] = cur.wd1; m_busy[k][cur.sw1] = 1'b0; end
        if (cur.wr2) begin m_regs[k][cur.sw2] = cur.wd2; m_busy[k][cur.sw2] = 1'b0; end
        if (cur.res) m_busy[k][cur.sres] = 1'b1;
        if (zr[k]) begin m_regs[k][0] = '0; m_busy[k][0] = 1'b0; end
        if (cur.rd) begin
          m_a[k] = na; m_b[k] = nb;
          m_ba[k] = m_busy[k][cur.sr1];
          m_bb[k] = m_busy[k][cur.sr2];
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic compare_all(string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s.u%0d.outA", tag, k), dut_a[k], m_a[k]);
      chk($sformatf("%s.u%0d.outB", tag, k), dut_b[k], m_b[k]);
      chk($sformatf("%s.u%0d.busyA", tag, k), DW'(dut_ba[k]), DW'(m_ba[k]));
      chk($sformatf("%s.u%0d.busyB", tag, k), DW'(dut_bb[k]), DW'(m_bb[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    txn++;
    $display("txn %0d en=%b w1=%b@%0d w2=%b@%0d res=%b@%0d rd=%b %0d/%0d -> a=%h b=%h ba=%b bb=%b",
             txn, cur.en, cur.wr, cur.sw1, cur.wr2, cur.sw2, cur.res, cur.sres,
             cur.rd, cur.sr1, cur.sr2, dut_a[0], dut_b[0], dut_ba[0], dut_bb[0]);
    compare_all($sformatf("t%0d", txn));
  endtask

  function automatic vec_t mk(logic en, logic wr, logic [AW-1:0] sw1, logic [DW-1:0] wd1,
                              logic wr2, logic [AW-1:0] sw2, logic [DW-1:0] wd2,
                              logic res, logic [AW-1:0] sres,
                              logic rd, logic [AW-1:0] sr1, logic [AW-1:0] sr2,
                              logic [DW-1:0] ea, logic [DW-1:0] eb, logic eba, logic ebb);
    vec_t v;
    v.s.en = en; v.s.wr = wr; v.s.sw1 = sw1; v.s.wd1 = wd1;
    v.s.wr2 = wr2; v.s.sw2 = sw2; v.s.wd2 = wd2;
    v.s.res = res; v.s.sres = sres;
    v.s.rd = rd; v.s.sr1 = sr1; v.s.sr2 = sr2;
    v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb;
    return v;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.en = 1'b1; s.wr = 1'b0; s.sw1 = '0; s.wd1 = '0;
    s.wr2 = 1'b0; s.sw2 = '0; s.wd2 = '0;
    s.res = 1'b0; s.sres = '0;
    s.rd = 1'b0; s.sr1 = '0; s.sr2 = '0;
    return s;
  endfunction

  vec_t vt [16];

  initial begin
    // Expected values below are for instance 0 (zero register on, bypass on).
    vt[0]  = mk(1,0,0,0,        0,0,0,        0,0, 1,1,2, 0,0,0,0);
    vt[1]  = mk(1,1,1,123,      0,0,0,        0,0, 0,0,0, 0,0,0,0);
    vt[2]  = mk(1,0,0,0,        0,0,0,        0,0, 1,1,2, 123,0,0,0);
    vt[3]  = mk(1,1,3,456,      0,0,0,        0,0, 1,3,1, 456,123,0,0);
    vt[4]  = mk(1,1,5,'hAAAA,   1,5,'h5555,   0,0, 0,0,0, 456,123,0,0);
    vt[5]  = mk(1,0,0,0,        0,0,0,        0,0, 1,5,3, 'h5555,456,0,0);
    vt[6]  = mk(1,1,0,123,      1,0,123,      1,0, 1,0,5, 0,'h5555,0,0);
    vt[7]  = mk(1,0,0,0,        0,0,0,        0,0, 1,0,0, 0,0,0,0);
    vt[8]  = mk(1,0,0,0,        0,0,0,        1,7, 0,0,0, 0,0,0,0);
    vt[9]  = mk(1,0,0,0,        0,0,0,        0,0, 1,7,1, 0,123,1,0);
    vt[10] = mk(1,1,7,9,        0,0,0,        0,0, 0,0,0, 0,123,1,0);
    vt[11] = mk(1,0,0,0,        0,0,0,        0,0, 1,7,1, 9,123,0,0);
    vt[12] = mk(1,1,7,10,       0,0,0,        1,7, 1,7,7, 10,10,1,1);
    vt[13] = mk(0,1,7,11,       0,0,0,        0,0, 1,7,1, 10,10,1,1);
    vt[14] = mk(1,0,0,0,        0,0,0,        0,0, 1,7,3, 10,456,1,0);
    vt[15] = mk(1,1,2,'h11,     1,2,'h22,     0,0, 1,2,2, 'h22,'h22,0,0);

    cur = idle();
    cur.rd = 1'b1;
    model_reset();
    #50;
    compare_all("reset");
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cur = vt[i].s;
      step();
      chk($sformatf("vec%0d.outA", i), dut_a[0], vt[i].ea);
      chk($sformatf("vec%0d.outB", i), dut_b[0], vt[i].eb);
      chk($sformatf("vec%0d.busyA", i), DW'(dut_ba[0]), DW'(vt[i].eba));
      chk($sformatf("vec%0d.busyB", i), DW'(dut_bb[0]), DW'(vt[i].ebb));
    end

    // Forwarding on vs off: same-cycle read sees new data only with bypass.
    cur = idle(); cur.wr = 1'b1; cur.sw1 = 4; cur.wd1 = 'h456; cur.rd = 1'b1; cur.sr1 = 4; cur.sr2 = 0;
    step();
    chk("bypass_on.outA", dut_a[0], 'h456);
    chk("bypass_off.outA", dut_a[1], '0);
    cur = idle(); cur.rd = 1'b1; cur.sr1 = 4; cur.sr2 = 0;
    step();
    chk("bypass_off_late.outA", dut_a[1], 'h456);
    chk("zero_off.outB", dut_b[2], 123);
    chk("zero_off.busyB", DW'(dut_bb[2]), 1);
    chk("zero_on.outB", dut_b[0], '0);

    for (int i = 0; i < 400; i++) begin
      cur.en   = ($urandom_range(0, 9) != 0);
      cur.wr   = $urandom_range(0, 1) == 1;
      cur.sw1  = AW'($urandom);
      cur.wd1  = $urandom;
      cur.wr2  = $urandom_range(0, 2) == 0;
      cur.sw2  = AW'($urandom);
      cur.wd2  = $urandom;
      cur.res  = $urandom_range(0, 2) == 0;
      cur.sres = AW'($urandom);
      cur.rd   = $urandom_range(0, 3) != 0;
      cur.sr1  = AW'($urandom);
      cur.sr2  = AW'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all($sformatf("arst%0d", i));
        @(posedge clk);
        #1 rst = 1'b0;
        compare_all($sformatf("arst_hold%0d", i));
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
